cpu_fetch_queue: RTL and testbench
==================================

Name: cpu_fetch_queue

Overview:
- Instruction queue between the fetch stage and decode; decouples icache/TLB hit timing from decode stalls.
- Captures each fetched {pc, instr, fault} when fetch presents a valid result and presents entries to decode in program order under a valid/ready handshake.
- A flush (jump/exception redirect) discards all queued entries in one cycle.
- Also emits the accept pulse the upstream PC register uses to advance to next_pc.

Parameters:
- ADDR_WIDTH, 32, virtual PC width.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-low; reset==0 on a rising edge resets the block.
- in_valid  input  1  fetch result available: cache_hit && (tlb_hit || !tlb_enable), or a TLB fault.
- in_pc  input  ADDR_WIDTH  PC of the fetched instruction.
- in_instr  input  DATA_WIDTH  fetched instruction word.
- in_fault  input  1  TLB miss on this fetch; travels with the entry, instr is don't-care.
- in_ready  output  1  queue can accept this cycle.
- in_accept  output  1  in_valid && in_ready && !flush; upstream PC advances on this.
- out_valid  output  1  head entry available to decode.
- out_pc  output  ADDR_WIDTH  head PC.
- out_instr  output  DATA_WIDTH  head instruction.
- out_fault  output  1  head fault flag.
- out_ready  input  1  decode consumes head this cycle.
- flush  input  1  redirect; discard all entries.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries with rd_ptr and wr_ptr ($clog2(DEPTH) bits each; wrap DEPTH-1 -> 0 naturally) and a count register.
- Reset (reset==0 at a clock edge): rd_ptr=wr_ptr=count=0. out_valid=0, in_ready=1, in_accept=0, count=0. Entry contents are not reset.
- in_ready = (count != DEPTH). It is a function of registered count only and does not depend on out_ready. When full, a same-cycle pop does not allow a push.
- in_accept is combinational: in_valid && in_ready && !flush.
- push = in_accept. Entry[wr_ptr] <= {in_pc, in_instr, in_fault}, and wr_ptr increments.
- out_valid = (count != 0).
- out_pc, out_instr and out_fault come from entry[rd_ptr] when out_valid=1. They are forced to 0 when out_valid=0, so the outputs are deterministic.
- pop = out_valid && out_ready && !flush. rd_ptr increments on pop.
- count_next: count+1 on push only, count-1 on pop only, unchanged on push and pop together (legal whenever 0<count<DEPTH).
- Latency: a pushed entry is visible at out_* the cycle after acceptance. There is no combinational bypass from in_* to out_*, even when the queue is empty.
- Empty with in_valid=1: push only; out_valid rises the next cycle.
- Full with out_ready=1: pop only; in_ready rises the next cycle.
- flush=1: rd_ptr, wr_ptr and count go to 0 at the next edge. Any concurrent push and pop are suppressed (flush dominates). out_valid=0 and in_ready=1 in the following cycle. A fetch result arriving in the flush cycle is dropped.
- Reset dominates flush. Reset asserted mid-operation discards all entries exactly as a flush does.
- If in_valid=1 and in_ready=0, nothing is written. Upstream must hold pc and instr stable, which it does because in_accept=0 blocks the PC advance.
- Fault entries are queued and popped like normal entries. The queue takes no exception action; decode and later stages own that.
- Assertions for verification: count never exceeds DEPTH; no push while count==DEPTH; no pop while count==0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, count=0, in_ready=1, out_pc=0. After release, push pc=0x1000, instr=0xDEADBEEF -> out_valid=1 one cycle later with those values.
- Fill and order: out_ready=0, push pc 0x0,0x4,0x8,0xC -> count=4, in_ready=0, and a fifth in_valid gives in_accept=0. Then out_ready=1 -> pops 0x0,0x4,0x8,0xC in order; count reaches 0 after 4 cycles.
- Wrap-around: run 10 continuous push/pop cycles with out_ready=1 and pcs 0x100+4k -> outputs in order with no loss; count stays 1 after the first push.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> one pop, no push, count=3. Next cycle in_ready=1 and the held entry is accepted.
- Flush dominance: count=2, flush=1 with in_valid=1 and out_ready=1 -> in_accept=0, no pop observed. Next cycle count=0, out_valid=0. The next push appears at out_* as the sole entry.
- Fault propagation and mid-op reset: push in_fault=1 with pc=0x2000 -> out_fault=1 and out_pc=0x2000 at the head. With count=3, assert reset=0 for one cycle -> count=0 and out_valid=0 at the next edge.

Source files
------------

// File: rtl/cpu_fetch_queue_if.sv
// Fetch/decode handshake bundle for the fetch queue.
// Upstream (fetch + decode) is the master; the queue is the slave.
interface cpu_fetch_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_instr;
    logic                  in_fault;
    logic                  in_ready;
    logic                  in_accept;

    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_instr;
    logic                  out_fault;
    logic                  out_ready;

    modport master (
        output in_valid, in_pc, in_instr, in_fault, out_ready,
        input  in_ready, in_accept, out_valid, out_pc, out_instr, out_fault
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_fault, out_ready,
        output in_ready, in_accept, out_valid, out_pc, out_instr, out_fault
    );
endinterface

// File: rtl/cpu_fetch_queue.sv
// In-order instruction queue between fetch and decode; single-cycle flush,
// and the accept pulse that advances the upstream PC.
module cpu_fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    cpu_fetch_queue_if.slave           fq,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
        logic                  fault;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          full, push, pop;

    // in_ready looks only at registered occupancy, so a full queue never
    // accepts even when decode pops in the same cycle.
    assign full         = (count == CW'(DEPTH));
    assign push         = fq.in_valid && !full && !flush;
    assign fq.in_ready  = !full;
    assign fq.in_accept = push;

    assign fq.out_valid = (count != '0);
    assign pop          = fq.out_valid && fq.out_ready && !flush;

    // Head outputs are zeroed when empty so decode never sees stale data.
    assign head         = mem[rd_ptr];
    assign fq.out_pc    = fq.out_valid ? head.pc    : '0;
    assign fq.out_instr = fq.out_valid ? head.instr : '0;
    assign fq.out_fault = fq.out_valid ? head.fault : 1'b0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= '{pc: fq.in_pc, instr: fq.in_instr, fault: fq.in_fault};
    end

    a_count_max: assert property (@(posedge clock) disable iff (!reset)
        count <= CW'(DEPTH));
    a_no_push_full: assert property (@(posedge clock) disable iff (!reset)
        full |-> !push);
    a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset)
        (count == '0) |-> !pop);
endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed bench for cpu_fetch_queue: reset, ordering, wrap, full+pop,
// flush dominance, fault propagation and mid-operation reset.
module tb_cpu_fetch_queue;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] count;
    int         vectors = 0;
    int         miscompares = 0;

    cpu_fetch_queue_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    cpu_fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .fq    (bus),
        .flush (flush),
        .count (count)
    );

    always #5 clock = ~clock;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = instr;
        bus.in_fault = fault;
        tick();
        bus.in_valid = 1'b0;
        bus.in_fault = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) if (count != 0) tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h1000;
        bus.in_instr = 32'hDEADBEEF;
        tick();
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        vectors++; if (bus.out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc got=%h exp=0", bus.out_pc); end
        reset = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL first_push_valid got=%b exp=1", bus.out_valid); end
        vectors++; if (bus.out_pc !== 32'h1000) begin miscompares++; $display("FAIL first_push_pc got=%h exp=1000", bus.out_pc); end
        vectors++; if (bus.out_instr !== 32'hDEADBEEF) begin miscompares++; $display("FAIL first_push_instr got=%h exp=deadbeef", bus.out_instr); end
        drain();
    endtask

    task automatic test_fill_order();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count got=%0d exp=4", count); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h10;
        #1;
        vectors++; if (bus.in_accept !== 1'b0) begin miscompares++; $display("FAIL fill_fifth_accept got=%b exp=0", bus.in_accept); end
        tick();
        bus.in_valid = 1'b0;
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_fifth_count got=%0d exp=4", count); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.out_pc !== 32'(i * 4) || bus.out_instr !== 32'hA000_0000 + 32'(i))
                begin miscompares++; $display("FAIL fill_pop%0d got=%h/%h exp=%h/%h", i, bus.out_pc, bus.out_instr, i * 4, 32'hA000_0000 + 32'(i)); end
            tick();
        end
        bus.out_ready = 1'b0;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL fill_drained_count got=%0d exp=0", count); end
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin miscompares++; $display("FAIL empty_outputs got=%b/%h exp=0/0", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_wrap();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_pc    = 32'h100 + 32'(4 * k);
            bus.in_instr = 32'hB000_0000 + 32'(k);
            tick();
            vectors++; if (count !== 3'd1 || bus.out_pc !== 32'h100 + 32'(4 * k) || bus.out_instr !== 32'hB000_0000 + 32'(k))
                begin miscompares++; $display("FAIL wrap_k%0d got cnt=%0d pc=%h instr=%h exp cnt=1 pc=%h", k, count, bus.out_pc, bus.out_instr, 32'h100 + 32'(4 * k)); end
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL wrap_final_count got=%0d exp=0", count); end
    endtask

    task automatic test_full_pop();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'h300 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h310;
        bus.in_instr  = 32'hC000_0004;
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.in_accept !== 1'b0) begin miscompares++; $display("FAIL full_pop_accept got=%b exp=0", bus.in_accept); end
        tick();
        bus.out_ready = 1'b0;
        vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL full_pop_count got=%0d exp=3", count); end
        vectors++; if (bus.out_pc !== 32'h304) begin miscompares++; $display("FAIL full_pop_head got=%h exp=304", bus.out_pc); end
        vectors++; if (bus.in_ready !== 1'b1 || bus.in_accept !== 1'b1) begin miscompares++; $display("FAIL full_pop_reopen got=%b/%b exp=1/1", bus.in_ready, bus.in_accept); end
        tick();
        bus.in_valid = 1'b0;
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_pop_refill got=%0d exp=4", count); end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            vectors++; if (bus.out_pc !== 32'h300 + 32'(4 * i)) begin miscompares++; $display("FAIL full_pop_seq%0d got=%h exp=%h", i, bus.out_pc, 32'h300 + 32'(4 * i)); end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        push_one(32'h400, 32'hD000_0000, 1'b0);
        push_one(32'h404, 32'hD000_0001, 1'b0);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h408;
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.in_accept !== 1'b0) begin miscompares++; $display("FAIL flush_accept got=%b exp=0", bus.in_accept); end
        tick();
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vectors++; if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin miscompares++; $display("FAIL flush_state got cnt=%0d ov=%b ir=%b exp 0/0/1", count, bus.out_valid, bus.in_ready); end
        push_one(32'h500, 32'hD000_0500, 1'b0);
        vectors++; if (count !== 3'd1 || bus.out_pc !== 32'h500 || bus.out_instr !== 32'hD000_0500)
            begin miscompares++; $display("FAIL flush_next_push got cnt=%0d pc=%h exp 1/500", count, bus.out_pc); end
        drain();
    endtask

    task automatic test_fault_reset();
        push_one(32'h2000, 32'hFFFF_FFFF, 1'b1);
        vectors++; if (bus.out_fault !== 1'b1 || bus.out_pc !== 32'h2000) begin miscompares++; $display("FAIL fault_head got=%b/%h exp=1/2000", bus.out_fault, bus.out_pc); end
        push_one(32'h2004, 32'h1, 1'b0);
        push_one(32'h2008, 32'h2, 1'b0);
        vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL midreset_pre_count got=%0d exp=3", count); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++; if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_fault !== 1'b0)
            begin miscompares++; $display("FAIL midreset_state got cnt=%0d ov=%b of=%b exp 0/0/0", count, bus.out_valid, bus.out_fault); end
        push_one(32'h3000, 32'h3, 1'b0);
        vectors++; if (bus.out_pc !== 32'h3000 || bus.out_fault !== 1'b0) begin miscompares++; $display("FAIL midreset_push got=%h/%b exp=3000/0", bus.out_pc, bus.out_fault); end
        drain();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.in_fault  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fill_order();
        test_wrap();
        test_full_pop();
        test_flush();
        test_fault_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
